// File: rtl/prune_ctrl.sv
// Tile sequencer between an input activation stream and a combinational pruning unit.
// Each element is registered with a one-deep output stage; kept elements are counted per tile.
//
// state   | meaning
// --------+-----------------------------------------------------------
// S_IDLE  | waiting for start; nz count and last outputs held
// S_RUN   | accepting elements until the remaining count reaches zero
// S_DRAIN | last element registered, waiting for it to be consumed
module prune_ctrl #(
  parameter int N  = 64,
  parameter int LW = 7
) (
  input  logic          i_clk,
  input  logic          i_rst,
  input  logic          i_start,
  input  logic [LW-1:0] i_len,
  input  logic [1:0]    i_th_cfg,
  input  logic [1:0]    i_fp_dst_cfg,
  input  logic          i_in_valid,
  output logic          o_in_ready,
  input  logic [7:0]    i_in_data,
  output logic [7:0]    o_pru_in,
  output logic [1:0]    o_pru_th,
  output logic [1:0]    o_pru_fp_dst,
  input  logic [7:0]    i_pru_out,
  input  logic          i_pru_keep,
  output logic          o_out_valid,
  input  logic          i_out_ready,
  output logic [7:0]    o_out_data,
  output logic          o_out_keep,
  output logic          o_out_last,
  output logic          o_busy,
  output logic          o_done,
  output logic [LW-1:0] o_nz_count
);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_RUN   = 2'd1;
  localparam logic [1:0] S_DRAIN = 2'd2;

  localparam logic [LW-1:0] L_NMAX = LW'(N);
  localparam logic [LW-1:0] L_ONE  = LW'(1);

  logic [1:0]    r_state;
  logic [1:0]    r_th;
  logic [1:0]    r_fp_dst;
  logic [LW-1:0] r_rem;
  logic [LW-1:0] r_nz;
  logic          r_out_valid;
  logic [7:0]    r_out_data;
  logic          r_out_keep;
  logic          r_out_last;
  logic          r_done;

  logic [LW-1:0] w_len_eff;
  logic          w_in_ready;
  logic          w_accept;
  logic          w_drain;

  // Oversized tile requests are clamped rather than rejected.
  assign w_len_eff  = (i_len > L_NMAX) ? L_NMAX : i_len;
  assign w_in_ready = (r_state == S_RUN) && (!r_out_valid || i_out_ready);
  assign w_accept   = i_in_valid && w_in_ready;
  assign w_drain    = r_out_valid && i_out_ready;

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_state     <= S_IDLE;
      r_th        <= '0;
      r_fp_dst    <= '0;
      r_rem       <= '0;
      r_nz        <= '0;
      r_out_valid <= 1'b0;
      r_out_data  <= '0;
      r_out_keep  <= 1'b0;
      r_out_last  <= 1'b0;
      r_done      <= 1'b0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (i_start) begin
            r_nz <= '0;
            if (w_len_eff == '0) begin
              r_done <= 1'b1;
            end else begin
              r_th     <= i_th_cfg;
              r_fp_dst <= i_fp_dst_cfg;
              r_rem    <= w_len_eff;
              r_state  <= S_RUN;
            end
          end
        end
        S_RUN: begin
          // An accept reloads the output stage even while it is being drained.
          if (w_accept) begin
            r_out_valid <= 1'b1;
            r_out_data  <= i_pru_out;
            r_out_keep  <= i_pru_keep;
            r_out_last  <= (r_rem == L_ONE);
            r_rem       <= r_rem - L_ONE;
            if (i_pru_keep) r_nz <= r_nz + L_ONE;
            if (r_rem == L_ONE) r_state <= S_DRAIN;
          end else if (w_drain) begin
            r_out_valid <= 1'b0;
          end
        end
        S_DRAIN: begin
          if (w_drain) begin
            r_out_valid <= 1'b0;
            r_done      <= 1'b1;
            r_state     <= S_IDLE;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign o_in_ready   = w_in_ready;
  assign o_pru_in     = i_in_data;
  assign o_pru_th     = r_th;
  assign o_pru_fp_dst = r_fp_dst;
  assign o_out_valid  = r_out_valid;
  assign o_out_data   = r_out_data;
  assign o_out_keep   = r_out_keep;
  assign o_out_last   = r_out_last;
  assign o_busy       = (r_state != S_IDLE);
  assign o_done       = r_done;
  assign o_nz_count   = r_nz;

endmodule

// File: tb/tb_prune_ctrl.sv
// Directed bench for prune_ctrl: cycle vector table plus hand sequences for stall,
// clamped back-to-back tile, ignored restart and mid-tile reset.
module tb_prune_ctrl;

  localparam int N  = 6;
  localparam int LW = 4;

  logic          clk = 1'b0;
  logic          rst;
  logic          start;
  logic [LW-1:0] len;
  logic [1:0]    th_cfg, fp_cfg;
  logic          in_valid, in_ready;
  logic [7:0]    in_data, pru_in, pru_out;
  logic [1:0]    pru_th, pru_fp;
  logic          pru_keep;
  logic          out_valid, out_ready, out_keep, out_last, busy, done;
  logic [7:0]    out_data;
  logic [LW-1:0] nz;

  int n_vec = 0;
  int n_err = 0;
  logic [7:0] data_tab [16];

  always #5 clk = ~clk;

  prune_ctrl #(.N(N), .LW(LW)) dut (
    .i_clk(clk), .i_rst(rst), .i_start(start), .i_len(len),
    .i_th_cfg(th_cfg), .i_fp_dst_cfg(fp_cfg),
    .i_in_valid(in_valid), .o_in_ready(in_ready), .i_in_data(in_data),
    .o_pru_in(pru_in), .o_pru_th(pru_th), .o_pru_fp_dst(pru_fp),
    .i_pru_out(pru_out), .i_pru_keep(pru_keep),
    .o_out_valid(out_valid), .i_out_ready(out_ready),
    .o_out_data(out_data), .o_out_keep(out_keep), .o_out_last(out_last),
    .o_busy(busy), .o_done(done), .o_nz_count(nz)
  );

  // Pruning unit model: keep values strictly above a code-selected threshold.
  function automatic logic keep_of(input logic [7:0] d, input logic [1:0] th);
    logic [7:0] t;
    case (th)
      2'd0:    t = 8'd0;
      2'd1:    t = 8'd3;
      2'd2:    t = 8'd15;
      default: t = 8'd63;
    endcase
    return d > t;
  endfunction

  assign pru_keep = keep_of(pru_in, pru_th);
  assign pru_out  = pru_keep ? pru_in : 8'h00;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h want %0h", name, act, exp);
    end
  endtask

  typedef struct {
    logic       start;
    logic [3:0] len;
    logic [1:0] th;
    logic       iv;
    logic [7:0] id;
    logic       ordy;
    logic       e_ir, e_ov;
    logic [7:0] e_od;
    logic       e_k, e_l, e_busy, e_done;
    logic [3:0] e_nz;
  } vec_t;

  function automatic vec_t mk(input logic s, input logic [3:0] l, input logic [1:0] t,
                              input logic iv, input logic [7:0] id, input logic ordy,
                              input logic ir, input logic ov, input logic [7:0] od,
                              input logic k, input logic la, input logic b, input logic dn,
                              input logic [3:0] z);
    vec_t v;
    v.start = s; v.len = l; v.th = t; v.iv = iv; v.id = id; v.ordy = ordy;
    v.e_ir = ir; v.e_ov = ov; v.e_od = od; v.e_k = k; v.e_l = la;
    v.e_busy = b; v.e_done = dn; v.e_nz = z;
    return v;
  endfunction

  task automatic stream(input int tlen, input logic [1:0] th, input logic [1:0] fp,
                        input int stall_at, input int stall_n, input bit glitch, input int exp_n);
    int sent, recv, nz_exp, n_last, first_hs, last_hs;
    bit acc, hs, was_stalled;
    logic [7:0] hold_d, exp_d;
    logic hold_k, hold_l, exp_k;
    start = 1'b1; len = tlen[LW-1:0]; th_cfg = th; fp_cfg = fp;
    in_valid = 1'b0; out_ready = 1'b1;
    @(posedge clk); #1;
    start = 1'b0; len = '0; th_cfg = ~th; fp_cfg = ~fp;
    sent = 0; recv = 0; nz_exp = 0; n_last = 0; first_hs = -1; last_hs = -1;
    was_stalled = 0; hold_d = '0; hold_k = 0; hold_l = 0;
    for (int cyc = 0; cyc < 60 && recv < exp_n; cyc++) begin
      in_valid  = (sent < exp_n);
      in_data   = (sent < exp_n) ? data_tab[sent] : 8'h00;
      out_ready = !(cyc >= stall_at && cyc < stall_at + stall_n);
      start     = glitch && (cyc == 2);
      if (start) len = 4'd1;
      @(negedge clk);
      acc = in_valid && in_ready;
      hs  = out_valid && out_ready;
      chk("pru_th", pru_th, th);
      chk("pru_fp", pru_fp, fp);
      chk("busy_run", busy, 1);
      if (out_valid && !out_ready) chk("stall_in_ready", in_ready, 0);
      if (was_stalled) chk("stall_hold", {out_data, out_keep, out_last}, {hold_d, hold_k, hold_l});
      was_stalled = out_valid && !out_ready;
      hold_d = out_data; hold_k = out_keep; hold_l = out_last;
      if (hs) begin
        exp_k = keep_of(data_tab[recv], th);
        exp_d = exp_k ? data_tab[recv] : 8'h00;
        chk($sformatf("out_elem%0d", recv), {out_data, out_keep, out_last},
            {exp_d, exp_k, 1'(recv == exp_n - 1)});
        if (exp_k) nz_exp++;
        if (out_last) n_last++;
        if (first_hs < 0) first_hs = cyc;
        last_hs = cyc;
        recv++;
      end
      if (acc) sent++;
      @(posedge clk); #1;
    end
    start = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
    chk("recv_count", recv, exp_n);
    chk("last_count", n_last, 1);
    if (stall_n == 0) chk("b2b_span", last_hs - first_hs, exp_n - 1);
    @(negedge clk);
    chk("done_pulse", {done, busy, in_ready, out_valid}, 4'b1000);
    chk("nz_final", nz, nz_exp);
    @(posedge clk); #1;
    @(negedge clk);
    chk("done_once", done, 0);
    chk("nz_hold", nz, nz_exp);
    @(posedge clk); #1;
  endtask

  initial begin
    vec_t tab [11];
    rst = 1'b1; start = 0; len = '0; th_cfg = '0; fp_cfg = '0;
    in_valid = 0; in_data = '0; out_ready = 1;

    // len=4 tile then a len=0 start; config/len changes after start must be ignored
    tab[0]  = mk(1, 4, 0, 0, 8'h00, 1,  0, 0, 8'h00, 0, 0, 0, 0, 0);
    tab[1]  = mk(0, 0, 3, 1, 8'h00, 1,  1, 0, 8'h00, 0, 0, 1, 0, 0);
    tab[2]  = mk(0, 0, 3, 1, 8'h05, 1,  1, 1, 8'h00, 0, 0, 1, 0, 0);
    tab[3]  = mk(0, 0, 3, 1, 8'h00, 1,  1, 1, 8'h05, 1, 0, 1, 0, 1);
    tab[4]  = mk(0, 0, 3, 1, 8'h7F, 1,  1, 1, 8'h00, 0, 0, 1, 0, 1);
    tab[5]  = mk(0, 0, 0, 0, 8'h00, 1,  0, 1, 8'h7F, 1, 1, 1, 0, 2);
    tab[6]  = mk(0, 0, 0, 0, 8'h00, 1,  0, 0, 8'h7F, 1, 1, 0, 1, 2);
    tab[7]  = mk(0, 0, 0, 0, 8'h00, 1,  0, 0, 8'h7F, 1, 1, 0, 0, 2);
    tab[8]  = mk(1, 0, 0, 1, 8'h33, 1,  0, 0, 8'h7F, 1, 1, 0, 0, 2);
    tab[9]  = mk(0, 0, 0, 1, 8'h33, 1,  0, 0, 8'h7F, 1, 1, 0, 1, 0);
    tab[10] = mk(0, 0, 0, 1, 8'h33, 1,  0, 0, 8'h7F, 1, 1, 0, 0, 0);

    repeat (2) @(posedge clk);
    #1 rst = 1'b0;

    for (int i = 0; i < 11; i++) begin
      start = tab[i].start; len = tab[i].len; th_cfg = tab[i].th;
      in_valid = tab[i].iv; in_data = tab[i].id; out_ready = tab[i].ordy;
      @(negedge clk);
      chk($sformatf("vec%0d", i),
          {in_ready, out_valid, out_data, out_keep, out_last, busy, done, nz, pru_in},
          {tab[i].e_ir, tab[i].e_ov, tab[i].e_od, tab[i].e_k, tab[i].e_l,
           tab[i].e_busy, tab[i].e_done, tab[i].e_nz, tab[i].id});
      @(posedge clk); #1;
    end
    start = 0; in_valid = 0;

    // len=3 with a 3-cycle output stall after the first output
    data_tab[0] = 8'h10; data_tab[1] = 8'h02; data_tab[2] = 8'h20;
    stream(3, 2'd1, 2'd2, 1, 3, 0, 3);

    // len=9 clamps to N=6, streamed back-to-back
    data_tab[0] = 8'h10; data_tab[1] = 8'h0F; data_tab[2] = 8'hFF;
    data_tab[3] = 8'h00; data_tab[4] = 8'h20; data_tab[5] = 8'h0E;
    stream(9, 2'd2, 2'd1, 0, 0, 0, N);

    // start with other config mid-tile is ignored
    data_tab[0] = 8'h01; data_tab[1] = 8'h04; data_tab[2] = 8'h00; data_tab[3] = 8'h10;
    stream(4, 2'd1, 2'd3, 0, 0, 1, 4);

    // asynchronous reset after 2 of 8 elements
    start = 1; len = 4'd8; th_cfg = 2'd2; fp_cfg = 2'd1;
    @(posedge clk); #1;
    start = 0; in_valid = 1; in_data = 8'h80; out_ready = 1;
    @(posedge clk); #1;
    in_data = 8'h81;
    @(posedge clk); #1;
    in_valid = 0;
    chk("pre_rst", {busy, out_valid, out_data, nz, pru_th}, {1'b1, 1'b1, 8'h81, 4'd2, 2'd2});
    #2 rst = 1'b1;
    #1;
    chk("async_rst",
        {in_ready, out_valid, out_data, out_keep, out_last, busy, done, nz, pru_th, pru_fp},
        26'd0);
    @(posedge clk); #1 rst = 1'b0;
    data_tab[0] = 8'h00; data_tab[1] = 8'h09;
    stream(2, 2'd0, 2'd2, 0, 0, 0, 2);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
